// File: rtl/definitions_pkg.sv
// Shared definitions for the traffic_lights command interface.
//   command_e        : command codes understood by traffic_lights (cmd_type_i)
//   req_kind_e       : high-level request kinds accepted by traffic_lights_cmd_gen
//   TIMES_BURST_LEN  : number of commands in a REQ_TIMES burst
//   times_slot_cmd() : command issued in a given slot of a REQ_TIMES burst
package definitions_pkg;

  typedef enum logic [2:0] {
    SET_OFF    = 3'd0,
    SET_ON     = 3'd1,
    SET_MANUAL = 3'd2,
    SET_RED    = 3'd3,
    SET_YELLOW = 3'd4,
    SET_GREEN  = 3'd5
  } command_e;

  typedef enum logic [1:0] {
    REQ_TIMES  = 2'd0,
    REQ_MANUAL = 2'd1,
    REQ_OFF    = 2'd2
  } req_kind_e;

  localparam int unsigned TIMES_BURST_LEN = 5;

  // Programming sequence: park the controller in manual mode, load the three
  // times, then hand control back to the automatic sequencer.
  function automatic command_e times_slot_cmd(input logic [2:0] slot);
    command_e cmd;
    case (slot)
      3'd0:    cmd = SET_MANUAL;
      3'd1:    cmd = SET_RED;
      3'd2:    cmd = SET_YELLOW;
      3'd3:    cmd = SET_GREEN;
      default: cmd = SET_ON;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/traffic_lights_cmd_gen.sv
// traffic_lights_cmd_gen
// Transmit side of the traffic_lights command interface. Accepts one
// high-level request at a time over valid/ready and expands it into the
// command burst traffic_lights expects, one command per slot, with
// CMD_GAP_CYCLES idle cycles between commands.
//
// Ports
//   clk_2k_i        in   2 kHz clock
//   srst_i          in   synchronous reset, active-high
//   req_valid_i     in   request valid
//   req_ready_o     out  request ready (IDLE and not in reset)
//   req_kind_i      in   req_kind_e
//   req_red_ms_i    in   red time in ms (REQ_TIMES)
//   req_yellow_ms_i in   yellow time in ms (REQ_TIMES)
//   req_green_ms_i  in   green time in ms (REQ_TIMES)
//   req_err_o       out  one-cycle pulse: accepted request was illegal, dropped
//   busy_o          out  burst in progress
//   cmd_valid_o     out  command valid
//   cmd_type_o      out  command_e
//   cmd_data_o      out  command data in ms (times only, else 0)
module traffic_lights_cmd_gen
  import definitions_pkg::*;
#(
  parameter int unsigned CMD_GAP_CYCLES = 0,
  parameter int unsigned MAX_TIME_MS    = 1000
) (
  input  logic                         clk_2k_i,
  input  logic                         srst_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [1:0]                   req_kind_i,
  input  logic [15:0]                  req_red_ms_i,
  input  logic [15:0]                  req_yellow_ms_i,
  input  logic [15:0]                  req_green_ms_i,
  output logic                         req_err_o,
  output logic                         busy_o,
  output logic                         cmd_valid_o,
  output logic [$bits(command_e)-1:0]  cmd_type_o,
  output logic [15:0]                  cmd_data_o
);

  localparam int unsigned GAP_W =
    (CMD_GAP_CYCLES == 0) ? 1 : $clog2(CMD_GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST =
    (CMD_GAP_CYCLES == 0) ? '0 : GAP_W'(CMD_GAP_CYCLES - 1);
  localparam logic [15:0] MAX_TIME        = 16'(MAX_TIME_MS);
  localparam logic [2:0]  TIMES_LAST_SLOT = 3'(TIMES_BURST_LEN - 1);

  generate
    if (MAX_TIME_MS > 32'h0000_FFFF) begin : g_max_time_check
      $error("MAX_TIME_MS must fit in the 16-bit command data field");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  state_e           state_reg,     state_next;
  logic [1:0]       kind_reg,      kind_next;
  logic [15:0]      red_reg,       red_next;
  logic [15:0]      yellow_reg,    yellow_next;
  logic [15:0]      green_reg,     green_next;
  logic [2:0]       slot_reg,      slot_next;
  logic [GAP_W-1:0] gap_cnt_reg,   gap_cnt_next;
  logic             cmd_valid_reg, cmd_valid_next;
  command_e         cmd_type_reg,  cmd_type_next;
  logic [15:0]      cmd_data_reg,  cmd_data_next;
  logic             err_reg,       err_next;

  logic             req_legal;
  logic [2:0]       last_slot;

  function automatic logic time_ok(input logic [15:0] t);
    return (t != 16'd0) && (t <= MAX_TIME);
  endfunction

  function automatic command_e slot_cmd(input logic [1:0] kind, input logic [2:0] slot);
    command_e cmd;
    case (kind)
      REQ_MANUAL: cmd = SET_MANUAL;
      REQ_OFF:    cmd = SET_OFF;
      default:    cmd = times_slot_cmd(slot);
    endcase
    return cmd;
  endfunction

  // Legality is judged on the live inputs because it is only consulted on
  // the accepting edge, when those inputs are the ones being registered.
  always_comb begin
    req_legal = 1'b0;
    case (req_kind_i)
      REQ_TIMES:  req_legal = time_ok(req_red_ms_i) && time_ok(req_yellow_ms_i)
                              && time_ok(req_green_ms_i);
      REQ_MANUAL: req_legal = 1'b1;
      REQ_OFF:    req_legal = 1'b1;
      default:    req_legal = 1'b0;
    endcase
  end

  assign last_slot = (kind_reg == REQ_TIMES) ? TIMES_LAST_SLOT : 3'd0;

  always_comb begin
    state_next     = state_reg;
    kind_next      = kind_reg;
    red_next       = red_reg;
    yellow_next    = yellow_reg;
    green_next     = green_reg;
    slot_next      = slot_reg;
    gap_cnt_next   = gap_cnt_reg;
    cmd_valid_next = 1'b0;
    cmd_type_next  = cmd_type_reg;
    cmd_data_next  = cmd_data_reg;
    err_next       = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (req_valid_i) begin
          kind_next    = req_kind_i;
          red_next     = req_red_ms_i;
          yellow_next  = req_yellow_ms_i;
          green_next   = req_green_ms_i;
          slot_next    = 3'd0;
          gap_cnt_next = '0;
          if (req_legal) begin
            state_next = ST_SEND;
          end else begin
            state_next = ST_ERR;
            err_next   = 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (slot_reg == last_slot) begin
          state_next = ST_IDLE;
        end else begin
          // Slot advances when leaving SEND so the next SEND entry already
          // sees the slot it must emit.
          slot_next = slot_reg + 3'd1;
          if (CMD_GAP_CYCLES == 0) begin
            state_next = ST_SEND;
          end else begin
            state_next   = ST_GAP;
            gap_cnt_next = '0;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          state_next = ST_SEND;
        end else begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end
      ST_ERR: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Command outputs are registered and loaded only on SEND entry, so
    // type/data hold steady through gap and idle cycles.
    if (state_next == ST_SEND) begin
      cmd_valid_next = 1'b1;
      cmd_type_next  = slot_cmd(kind_next, slot_next);
      cmd_data_next  = 16'd0;
      if (kind_next == REQ_TIMES) begin
        case (slot_next)
          3'd1:    cmd_data_next = red_next;
          3'd2:    cmd_data_next = yellow_next;
          3'd3:    cmd_data_next = green_next;
          default: cmd_data_next = 16'd0;
        endcase
      end
    end
  end

  always_ff @(posedge clk_2k_i) begin
    if (srst_i) begin
      state_reg     <= ST_IDLE;
      kind_reg      <= REQ_OFF;
      red_reg       <= 16'd0;
      yellow_reg    <= 16'd0;
      green_reg     <= 16'd0;
      slot_reg      <= 3'd0;
      gap_cnt_reg   <= '0;
      cmd_valid_reg <= 1'b0;
      cmd_type_reg  <= SET_OFF;
      cmd_data_reg  <= 16'd0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      kind_reg      <= kind_next;
      red_reg       <= red_next;
      yellow_reg    <= yellow_next;
      green_reg     <= green_next;
      slot_reg      <= slot_next;
      gap_cnt_reg   <= gap_cnt_next;
      cmd_valid_reg <= cmd_valid_next;
      cmd_type_reg  <= cmd_type_next;
      cmd_data_reg  <= cmd_data_next;
      err_reg       <= err_next;
    end
  end

  // Ready is gated by reset so nothing can be accepted while srst_i is high.
  assign req_ready_o = (state_reg == ST_IDLE) && !srst_i;
  assign busy_o      = (state_reg != ST_IDLE);
  assign cmd_valid_o = cmd_valid_reg;
  assign cmd_type_o  = cmd_type_reg;
  assign cmd_data_o  = cmd_data_reg;
  assign req_err_o   = err_reg;

endmodule

// File: tb/tb_traffic_lights_cmd_gen.sv
module tb_traffic_lights_cmd_gen;
  import definitions_pkg::*;

  logic clk_2k = 1'b0;
  always #5 clk_2k = ~clk_2k;

  logic srst = 1'b1;

  // dut0: CMD_GAP_CYCLES=0, dut1: CMD_GAP_CYCLES=2
  logic        v0, rdy0, err0, busy0, cv0;
  logic [1:0]  k0;
  logic [15:0] r0, y0, g0, cd0;
  logic [2:0]  ct0;
  logic        v1, rdy1, err1, busy1, cv1;
  logic [1:0]  k1;
  logic [15:0] r1, y1, g1, cd1;
  logic [2:0]  ct1;

  traffic_lights_cmd_gen #(.CMD_GAP_CYCLES(0), .MAX_TIME_MS(1000)) dut0 (
    .clk_2k_i(clk_2k), .srst_i(srst), .req_valid_i(v0), .req_ready_o(rdy0),
    .req_kind_i(k0), .req_red_ms_i(r0), .req_yellow_ms_i(y0), .req_green_ms_i(g0),
    .req_err_o(err0), .busy_o(busy0), .cmd_valid_o(cv0), .cmd_type_o(ct0),
    .cmd_data_o(cd0)
  );

  traffic_lights_cmd_gen #(.CMD_GAP_CYCLES(2), .MAX_TIME_MS(1000)) dut1 (
    .clk_2k_i(clk_2k), .srst_i(srst), .req_valid_i(v1), .req_ready_o(rdy1),
    .req_kind_i(k1), .req_red_ms_i(r1), .req_yellow_ms_i(y1), .req_green_ms_i(g1),
    .req_err_o(err1), .busy_o(busy1), .cmd_valid_o(cv1), .cmd_type_o(ct1),
    .cmd_data_o(cd1)
  );

  int cyc = 0;
  always @(posedge clk_2k) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [2:0]  typ;
    logic [15:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic push(input int sel, input int c, input logic [2:0] t, input logic [15:0] d);
    exp_t e;
    e.cyc  = c;
    e.typ  = t;
    e.data = d;
    if (sel == 0) q0.push_back(e);
    else          q1.push_back(e);
  endtask

  // Scoreboard for dut0
  always @(negedge clk_2k) begin
    exp_t e;
    if (cv0 === 1'b1) begin
      $display("dut0 cmd cyc=%0d type=%0d data=%0d", cyc, ct0, cd0);
      chk("cmd0_expected", 32'(q0.size() != 0), 32'd1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("cmd0_cycle", cyc, e.cyc);
        chk("cmd0_type", 32'(ct0), 32'(e.typ));
        chk("cmd0_data", 32'(cd0), 32'(e.data));
      end
    end
  end

  // Scoreboard for dut1, plus hold check of type/data through gap cycles
  logic [2:0]  last1_typ;
  logic [15:0] last1_data;
  always @(negedge clk_2k) begin
    exp_t e;
    if (cv1 === 1'b1) begin
      $display("dut1 cmd cyc=%0d type=%0d data=%0d", cyc, ct1, cd1);
      last1_typ  = ct1;
      last1_data = cd1;
      chk("cmd1_expected", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("cmd1_cycle", cyc, e.cyc);
        chk("cmd1_type", 32'(ct1), 32'(e.typ));
        chk("cmd1_data", 32'(cd1), 32'(e.data));
      end
    end else if (busy1 === 1'b1) begin
      chk("gap1_type_hold", 32'(ct1), 32'(last1_typ));
      chk("gap1_data_hold", 32'(cd1), 32'(last1_data));
    end
  end

  function automatic bit t_ok(input logic [15:0] t);
    return (t >= 16'd1) && (t <= 16'd1000);
  endfunction

  // Issue one request at a negedge, check the accept cycle and the return to IDLE.
  task automatic run_req(input int sel, input logic [1:0] kind, input logic [15:0] r,
                         input logic [15:0] y, input logic [15:0] g, input string tag);
    int  gc;
    int  base;
    int  ncmd;
    int  done_cyc;
    bit  legal;
    gc    = (sel == 0) ? 1 : 3;
    legal = (kind == 2'd0) ? (t_ok(r) && t_ok(y) && t_ok(g)) : (kind == 2'd1 || kind == 2'd2);
    ncmd  = !legal ? 0 : ((kind == 2'd0) ? 5 : 1);
    @(negedge clk_2k);
    chk({tag, "_ready_pre"}, 32'((sel == 0) ? rdy0 : rdy1), 32'd1);
    base = cyc + 1;
    if (ncmd == 5) begin
      push(sel, base,          SET_MANUAL, 16'd0);
      push(sel, base + gc,     SET_RED,    r);
      push(sel, base + 2 * gc, SET_YELLOW, y);
      push(sel, base + 3 * gc, SET_GREEN,  g);
      push(sel, base + 4 * gc, SET_ON,     16'd0);
    end else if (ncmd == 1) begin
      push(sel, base, (kind == 2'd1) ? SET_MANUAL : SET_OFF, 16'd0);
    end
    done_cyc = legal ? base + (ncmd - 1) * gc + 1 : base + 1;
    $display("%s req sel=%0d kind=%0d r=%0d y=%0d g=%0d legal=%0d", tag, sel, kind, r, y, g, legal);
    if (sel == 0) begin v0 = 1'b1; k0 = kind; r0 = r; y0 = y; g0 = g; end
    else          begin v1 = 1'b1; k1 = kind; r1 = r; y1 = y; g1 = g; end
    @(negedge clk_2k);
    // Scramble the request fields: the accepted values must already be latched.
    if (sel == 0) begin v0 = 1'b0; k0 = 2'd0; r0 = 16'($urandom); y0 = 16'($urandom); g0 = 16'($urandom); end
    else          begin v1 = 1'b0; k1 = 2'd0; r1 = 16'($urandom); y1 = 16'($urandom); g1 = 16'($urandom); end
    chk({tag, "_ready_drop"}, 32'((sel == 0) ? rdy0 : rdy1), 32'd0);
    chk({tag, "_err"},        32'((sel == 0) ? err0 : err1), 32'(!legal));
    chk({tag, "_busy"},       32'((sel == 0) ? busy0 : busy1), 32'd1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_2k);
      if (((sel == 0) ? rdy0 : rdy1) === 1'b1) break;
      chk({tag, "_busy_run"}, 32'((sel == 0) ? busy0 : busy1), 32'd1);
    end
    chk({tag, "_ready_back"},  32'((sel == 0) ? rdy0 : rdy1), 32'd1);
    chk({tag, "_done_cycle"},  cyc, done_cyc);
    chk({tag, "_err_cleared"}, 32'((sel == 0) ? err0 : err1), 32'd0);
    chk({tag, "_drained"},     32'((sel == 0) ? q0.size() : q1.size()), 32'd0);
  endtask

  initial begin
    int base;
    v0 = 1'b0; k0 = 2'd0; r0 = 16'd0; y0 = 16'd0; g0 = 16'd0;
    v1 = 1'b0; k1 = 2'd0; r1 = 16'd0; y1 = 16'd0; g1 = 16'd0;

    // Reset values
    repeat (3) @(negedge clk_2k);
    chk("rst_ready", 32'(rdy0), 32'd0);
    chk("rst_cmd_valid", 32'(cv0), 32'd0);
    chk("rst_cmd_type", 32'(ct0), 32'(SET_OFF));
    chk("rst_cmd_data", 32'(cd0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    srst = 1'b0;
    @(negedge clk_2k);
    chk("post_rst_ready0", 32'(rdy0), 32'd1);
    chk("post_rst_ready1", 32'(rdy1), 32'd1);

    // Main bursts
    run_req(0, 2'd0, 16'd7, 16'd3, 16'd9, "times_gap0");
    run_req(1, 2'd0, 16'd7, 16'd3, 16'd9, "times_gap2");
    run_req(0, 2'd0, 16'd1, 16'd1000, 16'd1, "times_bounds");

    // Illegal requests
    run_req(0, 2'd0, 16'd7, 16'd3, 16'd0, "green_zero");
    run_req(0, 2'd0, 16'd1001, 16'd3, 16'd9, "red_over_max");
    run_req(0, 2'd3, 16'd7, 16'd3, 16'd9, "kind_unknown");
    run_req(1, 2'd0, 16'd0, 16'd3, 16'd9, "gap2_red_zero");

    // Single-command requests
    run_req(1, 2'd1, 16'd0, 16'd0, 16'd0, "manual_gap2");
    run_req(1, 2'd2, 16'd0, 16'd0, 16'd0, "off_gap2");

    // REQ_MANUAL then REQ_OFF held back-to-back on valid
    @(negedge clk_2k);
    base = cyc + 1;
    push(0, base, SET_MANUAL, 16'd0);
    push(0, base + 2, SET_OFF, 16'd0);
    v0 = 1'b1; k0 = 2'd1;
    @(negedge clk_2k);
    chk("b2b_ready_low", 32'(rdy0), 32'd0);
    k0 = 2'd2;
    @(negedge clk_2k);
    chk("b2b_ready_high", 32'(rdy0), 32'd1);
    @(negedge clk_2k);
    v0 = 1'b0;
    chk("b2b_busy_off", 32'(busy0), 32'd1);
    @(negedge clk_2k);
    chk("b2b_ready_end", 32'(rdy0), 32'd1);
    chk("b2b_drained", 32'(q0.size()), 32'd0);

    // Reset during the SET_YELLOW slot
    @(negedge clk_2k);
    base = cyc + 1;
    push(0, base,     SET_MANUAL, 16'd0);
    push(0, base + 1, SET_RED,    16'd5);
    push(0, base + 2, SET_YELLOW, 16'd6);
    v0 = 1'b1; k0 = 2'd0; r0 = 16'd5; y0 = 16'd6; g0 = 16'd8;
    @(negedge clk_2k);
    v0 = 1'b0;
    @(negedge clk_2k);
    @(negedge clk_2k);
    chk("rst_mid_yellow_seen", 32'(cv0), 32'd1);
    srst = 1'b1;
    @(negedge clk_2k);
    chk("rst_mid_valid", 32'(cv0), 32'd0);
    chk("rst_mid_busy", 32'(busy0), 32'd0);
    srst = 1'b0;
    repeat (10) @(negedge clk_2k);
    chk("rst_mid_drained", 32'(q0.size()), 32'd0);
    chk("rst_mid_ready", 32'(rdy0), 32'd1);

    // A few random legal triples on the gapped instance
    for (int i = 0; i < 5; i++) begin
      run_req(1, 2'd0, 16'($urandom_range(1, 1000)), 16'($urandom_range(1, 1000)),
              16'($urandom_range(1, 1000)), "rand_gap2");
    end

    repeat (3) @(negedge clk_2k);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
